// File: rtl/temporal_encoder_arbiter.sv
// rtl/temporal_encoder_arbiter.sv - round-robin arbiter that feeds one HDC temporal encoder from NUM_CH sensor channels
//
// Purpose: picks one requesting channel at a time (round robin from a rotating
// pointer), issues its hypervector to the encoder, waits for the encoder result
// and returns it tagged with the originating channel. Exactly one transaction
// is in flight at any time.
//
// Ports:
//   Clk_CI, Reset_RBI           clock, asynchronous active-low reset
//   ReqValid_SI/ReqReady_SO     per-channel request handshake (ready is combinational in IDLE)
//   ReqHv_DI                    packed channel hypervectors, channel c at [c*HV_DIM +: HV_DIM]
//   EncValid_SO/EncReady_SI     hypervector issue handshake towards the encoder
//   EncHv_DO                    hypervector presented to the encoder
//   EncOutValid_SI/EncOutReady_SO, EncOutHv_DI   encoder result handshake
//   RspValid_SO/RspReady_SI     tagged result handshake
//   RspHv_DO, RspChan_DO        registered result and channel tag
//   Busy_SO                     high whenever a transaction is in progress

`ifndef HV_DIMENSION
`define HV_DIMENSION 32
`endif

module temporal_encoder_arbiter #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned HV_DIM = `HV_DIMENSION,
    parameter int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     Clk_CI,
    input  logic                     Reset_RBI,
    input  logic [NUM_CH-1:0]        ReqValid_SI,
    output logic [NUM_CH-1:0]        ReqReady_SO,
    input  logic [NUM_CH*HV_DIM-1:0] ReqHv_DI,
    output logic                     EncValid_SO,
    input  logic                     EncReady_SI,
    output logic [HV_DIM-1:0]        EncHv_DO,
    input  logic                     EncOutValid_SI,
    output logic                     EncOutReady_SO,
    input  logic [HV_DIM-1:0]        EncOutHv_DI,
    output logic                     RspValid_SO,
    input  logic                     RspReady_SI,
    output logic [HV_DIM-1:0]        RspHv_DO,
    output logic [CH_W-1:0]          RspChan_DO,
    output logic                     Busy_SO
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT    = 2'd2,
        S_RESPOND = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [CH_W-1:0]     ptr_q, ptr_d;
    logic [CH_W-1:0]     chan_q, chan_d;
    logic [HV_DIM-1:0]   hv_q, hv_d;
    logic [HV_DIM-1:0]   rsp_q, rsp_d;

    logic                grant_any;
    logic [CH_W-1:0]     grant_idx;
    logic [HV_DIM-1:0]   grant_hv;
    logic [CH_W:0]       cand;
    logic [NUM_CH-1:0]   req_rot;
    logic [CH_W:0]       ptr_inc;
    logic [CH_W-1:0]     ptr_nxt;

    // Round-robin search: candidate = ptr + i folded back into 0..NUM_CH-1.
    // One extra bit on cand holds ptr + i (at most 2*NUM_CH-2) before the fold,
    // so any NUM_CH, power of two or not, wraps correctly.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        req_rot   = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            cand = {1'b0, ptr_q} + (CH_W+1)'(i);
            if (cand >= (CH_W+1)'(NUM_CH)) begin
                cand = cand - (CH_W+1)'(NUM_CH);
            end
            req_rot = ReqValid_SI >> cand;
            if (!grant_any && req_rot[0]) begin
                grant_any = 1'b1;
                grant_idx = cand[CH_W-1:0];
            end
        end
    end

    // Hypervector of the granted channel.
    always_comb begin
        grant_hv = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (grant_idx == CH_W'(c)) begin
                grant_hv = ReqHv_DI[c*HV_DIM +: HV_DIM];
            end
        end
    end

    // Pointer moves one past the winner, wrapping at NUM_CH (stays 0 when NUM_CH=1).
    always_comb begin
        ptr_inc = {1'b0, grant_idx} + (CH_W+1)'(1);
        if (ptr_inc == (CH_W+1)'(NUM_CH)) begin
            ptr_nxt = '0;
        end else begin
            ptr_nxt = ptr_inc[CH_W-1:0];
        end
    end

    // Ready goes only to the winner, and never while reset is held low even
    // though the state register already reads IDLE.
    always_comb begin
        ReqReady_SO = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (Reset_RBI && (state_q == S_IDLE) && grant_any && (grant_idx == CH_W'(c))) begin
                ReqReady_SO[c] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        chan_d  = chan_q;
        hv_d    = hv_q;
        rsp_d   = rsp_q;
        case (state_q)
            S_IDLE: begin
                if (grant_any) begin
                    state_d = S_ISSUE;
                    ptr_d   = ptr_nxt;
                    chan_d  = grant_idx;
                    hv_d    = grant_hv;
                end
            end
            S_ISSUE: begin
                if (EncReady_SI) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (EncOutValid_SI) begin
                    rsp_d   = EncOutHv_DI;
                    state_d = S_RESPOND;
                end
            end
            S_RESPOND: begin
                if (RspReady_SI) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
        if (!Reset_RBI) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            chan_q  <= '0;
            hv_q    <= '0;
            rsp_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            chan_q  <= chan_d;
            hv_q    <= hv_d;
            rsp_q   <= rsp_d;
        end
    end

    assign EncValid_SO    = (state_q == S_ISSUE);
    assign EncHv_DO       = hv_q;
    assign EncOutReady_SO = (state_q == S_WAIT);
    assign RspValid_SO    = (state_q == S_RESPOND);
    assign RspHv_DO       = rsp_q;
    assign RspChan_DO     = chan_q;
    assign Busy_SO        = (state_q != S_IDLE);

endmodule

// File: tb/tb_temporal_encoder_arbiter.sv
// tb/tb_temporal_encoder_arbiter.sv - self-checking bench for temporal_encoder_arbiter

module tb_temporal_encoder_arbiter;

    localparam int NCH = 4;
    localparam int HV  = 16;

    logic              clk;
    logic              rst_n;
    logic [NCH-1:0]    req_valid;
    logic [NCH-1:0]    req_ready;
    logic [NCH*HV-1:0] req_hv;
    logic              enc_valid;
    logic              enc_ready;
    logic [HV-1:0]     enc_hv;
    logic              enc_out_valid;
    logic              enc_out_ready;
    logic [HV-1:0]     enc_out_hv;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [HV-1:0]     rsp_hv;
    logic [1:0]        rsp_chan;
    logic              busy;

    logic [2:0]        r3_valid;
    logic [2:0]        r3_ready;
    logic [3*HV-1:0]   r3_hv;
    logic              r3_enc_valid;
    logic              r3_enc_ready;
    logic [HV-1:0]     r3_enc_hv;
    logic              r3_out_valid;
    logic              r3_out_ready;
    logic [HV-1:0]     r3_out_hv;
    logic              r3_rsp_valid;
    logic              r3_rsp_ready;
    logic [HV-1:0]     r3_rsp_hv;
    logic [1:0]        r3_rsp_chan;
    logic              r3_busy;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;
    int dut_grants[$];

    temporal_encoder_arbiter #(.NUM_CH(NCH), .HV_DIM(HV)) dut (
        .Clk_CI(clk), .Reset_RBI(rst_n),
        .ReqValid_SI(req_valid), .ReqReady_SO(req_ready), .ReqHv_DI(req_hv),
        .EncValid_SO(enc_valid), .EncReady_SI(enc_ready), .EncHv_DO(enc_hv),
        .EncOutValid_SI(enc_out_valid), .EncOutReady_SO(enc_out_ready), .EncOutHv_DI(enc_out_hv),
        .RspValid_SO(rsp_valid), .RspReady_SI(rsp_ready), .RspHv_DO(rsp_hv),
        .RspChan_DO(rsp_chan), .Busy_SO(busy)
    );

    temporal_encoder_arbiter #(.NUM_CH(3), .HV_DIM(HV)) dut3 (
        .Clk_CI(clk), .Reset_RBI(rst_n),
        .ReqValid_SI(r3_valid), .ReqReady_SO(r3_ready), .ReqHv_DI(r3_hv),
        .EncValid_SO(r3_enc_valid), .EncReady_SI(r3_enc_ready), .EncHv_DO(r3_enc_hv),
        .EncOutValid_SI(r3_out_valid), .EncOutReady_SO(r3_out_ready), .EncOutHv_DI(r3_out_hv),
        .RspValid_SO(r3_rsp_valid), .RspReady_SI(r3_rsp_ready), .RspHv_DO(r3_rsp_hv),
        .RspChan_DO(r3_rsp_chan), .Busy_SO(r3_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: phase 0 idle, 1 issuing, 2 awaiting result, 3 responding.
    int            m_ph   = 0;
    int            m_ptr  = 0;
    int            m_chan = 0;
    logic [HV-1:0] m_hv   = '0;
    logic [HV-1:0] m_rsp  = '0;

    function automatic int m_pick(input logic [NCH-1:0] v, input int p);
        for (int i = 0; i < NCH; i++) begin
            if (v[(p + i) % NCH]) return (p + i) % NCH;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ph   <= 0;
            m_ptr  <= 0;
            m_chan <= 0;
            m_hv   <= '0;
            m_rsp  <= '0;
        end else begin
            case (m_ph)
                0: if (m_pick(req_valid, m_ptr) >= 0) begin
                    m_chan <= m_pick(req_valid, m_ptr);
                    m_hv   <= req_hv[HV*m_pick(req_valid, m_ptr) +: HV];
                    m_ptr  <= (m_pick(req_valid, m_ptr) + 1) % NCH;
                    m_ph   <= 1;
                end
                1: if (enc_ready) m_ph <= 2;
                2: if (enc_out_valid) begin
                    m_rsp <= enc_out_hv;
                    m_ph  <= 3;
                end
                default: if (rsp_ready) m_ph <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            logic [NCH-1:0] exp_rr;
            exp_rr = '0;
            if (m_ph == 0 && rst_n && m_pick(req_valid, m_ptr) >= 0) exp_rr[m_pick(req_valid, m_ptr)] = 1'b1;
            chk("req_ready", 32'(req_ready), 32'(exp_rr));
            chk("enc_valid", 32'(enc_valid), 32'(m_ph == 1));
            chk("enc_out_ready", 32'(enc_out_ready), 32'(m_ph == 2));
            chk("rsp_valid", 32'(rsp_valid), 32'(m_ph == 3));
            chk("busy", 32'(busy), 32'(m_ph != 0));
            if (m_ph == 1) chk("enc_hv", 32'(enc_hv), 32'(m_hv));
            if (m_ph == 3) begin
                chk("rsp_hv", 32'(rsp_hv), 32'(m_rsp));
                chk("rsp_chan", 32'(rsp_chan), 32'(m_chan));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            for (int c = 0; c < NCH; c++) begin
                if (req_ready[c]) dut_grants.push_back(c);
            end
        end
    end

    task automatic wait_idle(input string nm);
        for (int i = 0; i < 30; i++) begin
            if (!busy) return;
            @(posedge clk); #1;
        end
        chk({nm, "_idle_timeout"}, 32'(busy), 32'd0);
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_req_ready"}, 32'(req_ready), 32'd0);
        chk({nm, "_enc_valid"}, 32'(enc_valid), 32'd0);
        chk({nm, "_enc_out_ready"}, 32'(enc_out_ready), 32'd0);
        chk({nm, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({nm, "_busy"}, 32'(busy), 32'd0);
        chk({nm, "_rsp_hv"}, 32'(rsp_hv), 32'd0);
        chk({nm, "_rsp_chan"}, 32'(rsp_chan), 32'd0);
        chk({nm, "_enc_hv"}, 32'(enc_hv), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_ord[8];
        int k;
        int lat;
        bit found;
        logic [HV-1:0] hv_s;
        logic [1:0]    ch_s;
        exp_ord = '{0, 1, 2, 3, 0, 1, 2, 3};

        rst_n = 1'b1;
        req_valid = '0;
        req_hv = {16'hD003, 16'hC002, 16'hB001, 16'hA000};
        enc_ready = 1'b0;
        enc_out_valid = 1'b0;
        enc_out_hv = '0;
        rsp_ready = 1'b0;
        r3_valid = '0;
        r3_hv = {16'h3333, 16'h2222, 16'h1111};
        r3_enc_ready = 1'b1;
        r3_out_valid = 1'b1;
        r3_out_hv = 16'h7777;
        r3_rsp_ready = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        cmp_en = 1'b1;
        req_valid = 4'hF;
        chk_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset_clocked");
        req_valid = '0;
        rst_n = 1'b1;

        // Three-channel instance: ch2 grant wraps pointer to 0.
        @(posedge clk); #1;
        r3_valid = 3'b100;
        #1 chk("n3_grant_ch2", 32'(r3_ready), 32'h4);
        @(posedge clk); #1;
        r3_valid = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("n3_rsp_valid", 32'(r3_rsp_valid), 32'd1);
        chk("n3_rsp_chan", 32'(r3_rsp_chan), 32'd2);
        chk("n3_rsp_hv", 32'(r3_rsp_hv), 32'h7777);
        @(posedge clk); #1;
        chk("n3_idle", 32'(r3_busy), 32'd0);
        r3_valid = 3'b111;
        #1 chk("n3_ptr_wrap", 32'(r3_ready), 32'h1);
        r3_valid = '0;

        // All four channels continuously valid for eight transactions.
        enc_ready = 1'b1;
        enc_out_valid = 1'b1;
        enc_out_hv = 16'hBEEF;
        rsp_ready = 1'b1;
        dut_grants.delete();
        @(posedge clk); #1;
        req_valid = 4'hF;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (dut_grants.size() >= 8) break;
        end
        req_valid = '0;
        chk("rr_count", 32'(dut_grants.size()), 32'd8);
        for (int i = 0; i < 8 && i < dut_grants.size(); i++) chk("rr_order", 32'(dut_grants[i]), 32'(exp_ord[i]));
        wait_idle("rr");

        // Single request from ch2, minimum latency.
        req_hv[47:32] = 16'h5A5A;
        enc_out_hv = 16'hB00B;
        req_valid = 4'b0100;
        k = 0; lat = -1; found = 1'b0; hv_s = '0; ch_s = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid && !found) begin
                found = 1'b1;
                lat = k;
                hv_s = rsp_hv;
                ch_s = rsp_chan;
            end
            k++;
            @(posedge clk); #1;
            req_valid = '0;
            if (found) break;
        end
        chk("single_latency", 32'(lat), 32'd3);
        chk("single_rsp_hv", 32'(hv_s), 32'hB00B);
        chk("single_rsp_chan", 32'(ch_s), 32'd2);
        dut_grants.delete();
        req_valid = 4'hF;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (dut_grants.size() >= 1) break;
        end
        req_valid = '0;
        chk("ptr_after_ch2", 32'(dut_grants.size() > 0 ? dut_grants[0] : -1), 32'd3);
        wait_idle("after_ch2");

        // Encoder stalls in ISSUE for five cycles.
        enc_ready = 1'b0;
        enc_out_valid = 1'b0;
        rsp_ready = 1'b0;
        req_valid = 4'b0001;
        @(posedge clk); #1;
        req_valid = '0;
        chk("stall_hv_latched", 32'(enc_hv), 32'hA000);
        repeat (5) begin
            @(negedge clk);
            chk("stall_enc_valid", 32'(enc_valid), 32'd1);
            chk("stall_enc_hv", 32'(enc_hv), 32'hA000);
        end
        enc_ready = 1'b1;
        @(posedge clk); #1;
        chk("stall_to_wait", 32'(enc_out_ready), 32'd1);
        chk("stall_enc_valid_low", 32'(enc_valid), 32'd0);
        enc_ready = 1'b0;

        // Downstream stalls in RESPOND for four cycles.
        enc_out_hv = 16'hC0DE;
        enc_out_valid = 1'b1;
        @(posedge clk); #1;
        enc_out_valid = 1'b0;
        enc_out_hv = 16'hFFFF;
        req_valid = 4'hF;
        repeat (4) begin
            @(negedge clk);
            chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("hold_rsp_hv", 32'(rsp_hv), 32'hC0DE);
            chk("hold_rsp_chan", 32'(rsp_chan), 32'd0);
            chk("hold_no_grant", 32'(req_ready), 32'd0);
            chk("hold_busy", 32'(busy), 32'd1);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = '0;
        chk("hold_released", 32'(busy), 32'd0);

        // Asynchronous reset while waiting for the encoder result.
        enc_ready = 1'b1;
        req_valid = 4'b0010;
        @(posedge clk); #1;
        req_valid = '0;
        @(posedge clk); #1;
        chk("abort_in_wait", 32'(enc_out_ready), 32'd1);
        #2;
        rst_n = 1'b0;
        enc_out_valid = 1'b1;
        req_valid = 4'b0011;
        #1;
        chk_reset_outputs("async");
        @(posedge clk); #1;
        chk("async_no_rsp", 32'(rsp_valid), 32'd0);
        rst_n = 1'b1;
        enc_out_valid = 1'b0;
        #1 chk("post_reset_grant", 32'(req_ready), 32'h1);
        @(posedge clk); #1;
        req_valid = '0;
        enc_out_valid = 1'b1;
        wait_idle("post_reset");

        repeat (2) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
